otter_io_responder: RTL
=======================

OTTER_IO_RESPONDER -- requirements
Module: otter_io_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1100_0000, the base of the memory-mapped IO window.
REQ-002 SHALL have parameter SW_W, default 16, the switch and LED width.
REQ-003 SHALL have port CLK  in  1  the single clock for all state.
REQ-004 SHALL have port RESET  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port IOBUS_ADDR  in  32  the byte address from the CPU memory stage.
REQ-006 SHALL have port IOBUS_OUT  in  32  the CPU store data.
REQ-007 SHALL have port IOBUS_WR  in  1  the CPU store strobe, 1-cycle qualifier.
REQ-008 SHALL have port IOBUS_IN  out  32  the read data returned to the CPU.
REQ-009 SHALL have port SWITCHES  in  SW_W  asynchronous board switches.
REQ-010 SHALL have port LEDS  out  SW_W  the LED register.
REQ-011 SHALL have port INTR  out  1  the level interrupt request to the CPU INTR input.

Function
REQ-012 SHALL use this register map, offsets from BASE_ADDR: 0x00 SW (RO); 0x20 LED (RW); 0x40 CNT (RW); 0x44 CMP (RW); 0x48 CTRL (RW: bit0 EN, bit1 IRQ_EN, bit2 AUTO_RELOAD); 0x4C STAT (bit0 PEND, W1C); 0x50 PRESC (RW, 16 bits).
REQ-013 SHALL perform a write when IOBUS_WR=1 and IOBUS_ADDR matches a writable offset exactly; writes to unmapped or RO addresses SHALL be ignored.
REQ-014 SHALL register IOBUS_IN every cycle from the IOBUS_ADDR of the previous cycle, giving 1-cycle read latency that matches the synchronous data memory.
REQ-015 SHALL return 0 on IOBUS_IN for unmapped addresses, and zero-extend registers narrower than 32 bits.
REQ-016 SHALL pass SWITCHES through a 2-flop synchronizer; SW reads SHALL return the second flop.
REQ-017 SHALL drive LEDS directly from the LED register, SW_W LSBs of the write data.
REQ-018 SHALL use a 16-bit prescale counter: while EN=1 it increments each cycle; when it equals PRESC it SHALL reset to 0 and assert a 1-cycle tick. PRESC=0 therefore ticks every cycle.
REQ-019 SHALL, on each tick, compare CNT with CMP: if they are equal, set PEND; if AUTO_RELOAD=1 also load CNT=0, otherwise increment CNT.
REQ-020 SHALL wrap CNT from 0xFFFF_FFFF to 0 with no flag.
REQ-021 SHALL hold the prescaler and CNT frozen while EN=0; clearing EN SHALL also zero the prescale counter.
REQ-022 SHALL give a CPU write to CNT priority over a tick increment in the same cycle.
REQ-023 SHALL make a same-cycle PEND set from a tick win over a W1C clear.
REQ-024 SHALL drive INTR = PEND AND IRQ_EN as a registered output, asserting 1 cycle after PEND sets.
REQ-025 SHALL return the pre-update value when a register is read in the same cycle it is written.

Reset
REQ-026 SHALL, on RESET=1 at a CLK edge, clear LED, CNT, CMP, CTRL, STAT, PRESC, the prescale counter, the synchronizer flops, IOBUS_IN and INTR to 0.
REQ-027 SHALL let RESET override any same-cycle write or tick; after RESET, LEDS=0 and INTR=0 from the next cycle.

Structure
REQ-028 SHALL place the offset localparams and the CTRL bit indices in the shared OTTER package, beside opcode_t.
REQ-029 SHALL contain one sub-module, io_timer, holding the prescaler, CNT, CMP compare and PEND set logic; decode and readback stay in the top.

Verification
REQ-030 SHALL cover: write 0x0000_A5A5 to BASE+0x20 -> LEDS=16'hA5A5 next cycle; read BASE+0x20 -> IOBUS_IN=0x0000_A5A5 one cycle after the address.
REQ-031 SHALL cover: SWITCHES=16'h1234 held -> read BASE+0x00 returns 0x0000_1234 when issued at least 2 cycles after the change; BASE+0x30 returns 0.
REQ-032 SHALL cover: PRESC=0, CMP=5, CTRL=3'b111 -> PEND sets on the tick where CNT=5, CNT reloads to 0, INTR=1 one cycle later, and the event repeats every 6 cycles.
REQ-033 SHALL cover: PRESC=3, CTRL=3'b001 -> CNT increments every 4 cycles; with CTRL=3'b000 -> CNT holds.
REQ-034 SHALL cover: W1C of STAT in the same cycle as a compare-match tick -> PEND stays 1; a later W1C alone -> PEND=0 and INTR=0 next cycle.
REQ-035 SHALL cover: CNT=0xFFFF_FFFF with EN=1 -> wraps to 0; RESET asserted mid-count -> all registers and outputs 0 on the next cycle.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared OTTER definitions: RV32I major opcodes plus the IO responder register map.
package otter_pkg;

   typedef enum logic [6:0] {
      OP_LOAD   = 7'b0000011,
      OP_IMM    = 7'b0010011,
      OP_AUIPC  = 7'b0010111,
      OP_STORE  = 7'b0100011,
      OP_REG    = 7'b0110011,
      OP_LUI    = 7'b0110111,
      OP_BRANCH = 7'b1100011,
      OP_JALR   = 7'b1100111,
      OP_JAL    = 7'b1101111,
      OP_SYS    = 7'b1110011
   } opcode_t;

   // IO window offsets from BASE_ADDR
   localparam logic [31:0] IO_OFF_SW    = 32'h0000_0000;
   localparam logic [31:0] IO_OFF_LED   = 32'h0000_0020;
   localparam logic [31:0] IO_OFF_CNT   = 32'h0000_0040;
   localparam logic [31:0] IO_OFF_CMP   = 32'h0000_0044;
   localparam logic [31:0] IO_OFF_CTRL  = 32'h0000_0048;
   localparam logic [31:0] IO_OFF_STAT  = 32'h0000_004C;
   localparam logic [31:0] IO_OFF_PRESC = 32'h0000_0050;

   localparam int unsigned CTRL_EN          = 0;
   localparam int unsigned CTRL_IRQ_EN      = 1;
   localparam int unsigned CTRL_AUTO_RELOAD = 2;
   localparam int unsigned CTRL_W           = 3;
   localparam int unsigned PRESC_W          = 16;

endpackage

// File: rtl/io_timer.sv
// Prescaled 32-bit counter with compare match that sets a sticky pending flag.
module io_timer
   import otter_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_en,
   input  logic               i_auto_reload,
   input  logic               i_cnt_we,
   input  logic               i_cmp_we,
   input  logic               i_presc_we,
   input  logic               i_stat_w1c,
   input  logic [31:0]        i_wdata,
   output logic [31:0]        o_cnt,
   output logic [31:0]        o_cmp,
   output logic [PRESC_W-1:0] o_presc,
   output logic               o_pend
);

   logic [PRESC_W-1:0] r_presc;
   logic [PRESC_W-1:0] r_pcnt;
   logic [31:0]        r_cnt;
   logic [31:0]        r_cmp;
   logic               r_pend;
   logic               w_tick;
   logic               w_match;

   assign w_tick  = i_en && (r_pcnt == r_presc);
   assign w_match = (r_cnt == r_cmp);

   // CPU writes to CNT beat a tick; a match set beats a W1C clear
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_presc <= '0;
         r_pcnt  <= '0;
         r_cnt   <= '0;
         r_cmp   <= '0;
         r_pend  <= 1'b0;
      end else begin
         if (i_presc_we) r_presc <= i_wdata[PRESC_W-1:0];
         if (i_cmp_we)   r_cmp   <= i_wdata;

         if (!i_en || w_tick) r_pcnt <= '0;
         else                 r_pcnt <= r_pcnt + PRESC_W'(1);

         if (i_cnt_we)
            r_cnt <= i_wdata;
         else if (w_tick)
            r_cnt <= (w_match && i_auto_reload) ? 32'd0 : r_cnt + 32'd1;

         if (w_tick && w_match) r_pend <= 1'b1;
         else if (i_stat_w1c)   r_pend <= 1'b0;
      end
   end

   assign o_cnt   = r_cnt;
   assign o_cmp   = r_cmp;
   assign o_presc = r_presc;
   assign o_pend  = r_pend;

endmodule

// File: rtl/otter_io_responder.sv
// Memory-mapped IO block for the OTTER CPU: switches, LEDs and an interrupting timer.
module otter_io_responder
   import otter_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
   parameter int unsigned SW_W      = 16
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic [31:0]     IOBUS_ADDR,
   input  logic [31:0]     IOBUS_OUT,
   input  logic            IOBUS_WR,
   output logic [31:0]     IOBUS_IN,
   input  logic [SW_W-1:0] SWITCHES,
   output logic [SW_W-1:0] LEDS,
   output logic            INTR
);

   localparam logic [31:0] A_SW    = BASE_ADDR + IO_OFF_SW;
   localparam logic [31:0] A_LED   = BASE_ADDR + IO_OFF_LED;
   localparam logic [31:0] A_CNT   = BASE_ADDR + IO_OFF_CNT;
   localparam logic [31:0] A_CMP   = BASE_ADDR + IO_OFF_CMP;
   localparam logic [31:0] A_CTRL  = BASE_ADDR + IO_OFF_CTRL;
   localparam logic [31:0] A_STAT  = BASE_ADDR + IO_OFF_STAT;
   localparam logic [31:0] A_PRESC = BASE_ADDR + IO_OFF_PRESC;

   logic [SW_W-1:0]    r_sw_meta;
   logic [SW_W-1:0]    r_sw_sync;
   logic [SW_W-1:0]    r_led;
   logic [CTRL_W-1:0]  r_ctrl;
   logic [31:0]        r_iobus_in;
   logic               r_intr;

   logic               w_wr_led;
   logic               w_wr_cnt;
   logic               w_wr_cmp;
   logic               w_wr_ctrl;
   logic               w_wr_stat;
   logic               w_wr_presc;
   logic [31:0]        w_cnt;
   logic [31:0]        w_cmp;
   logic [PRESC_W-1:0] w_presc;
   logic               w_pend;
   logic [31:0]        w_rdata;

   assign w_wr_led   = IOBUS_WR && (IOBUS_ADDR == A_LED);
   assign w_wr_cnt   = IOBUS_WR && (IOBUS_ADDR == A_CNT);
   assign w_wr_cmp   = IOBUS_WR && (IOBUS_ADDR == A_CMP);
   assign w_wr_ctrl  = IOBUS_WR && (IOBUS_ADDR == A_CTRL);
   assign w_wr_stat  = IOBUS_WR && (IOBUS_ADDR == A_STAT);
   assign w_wr_presc = IOBUS_WR && (IOBUS_ADDR == A_PRESC);

   io_timer u_timer (
      .i_clk         (CLK),
      .i_rst         (RESET),
      .i_en          (r_ctrl[CTRL_EN]),
      .i_auto_reload (r_ctrl[CTRL_AUTO_RELOAD]),
      .i_cnt_we      (w_wr_cnt),
      .i_cmp_we      (w_wr_cmp),
      .i_presc_we    (w_wr_presc),
      .i_stat_w1c    (w_wr_stat && IOBUS_OUT[0]),
      .i_wdata       (IOBUS_OUT),
      .o_cnt         (w_cnt),
      .o_cmp         (w_cmp),
      .o_presc       (w_presc),
      .o_pend        (w_pend)
   );

   // Readback mux sees pre-update register values
   always_comb begin
      w_rdata = 32'd0;
      case (IOBUS_ADDR)
         A_SW:    w_rdata = 32'(r_sw_sync);
         A_LED:   w_rdata = 32'(r_led);
         A_CNT:   w_rdata = w_cnt;
         A_CMP:   w_rdata = w_cmp;
         A_CTRL:  w_rdata = 32'(r_ctrl);
         A_STAT:  w_rdata = 32'(w_pend);
         A_PRESC: w_rdata = 32'(w_presc);
         default: w_rdata = 32'd0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_sw_meta  <= '0;
         r_sw_sync  <= '0;
         r_led      <= '0;
         r_ctrl     <= '0;
         r_iobus_in <= '0;
         r_intr     <= 1'b0;
      end else begin
         r_sw_meta  <= SWITCHES;
         r_sw_sync  <= r_sw_meta;
         if (w_wr_led)  r_led  <= IOBUS_OUT[SW_W-1:0];
         if (w_wr_ctrl) r_ctrl <= IOBUS_OUT[CTRL_W-1:0];
         r_iobus_in <= w_rdata;
         r_intr     <= w_pend && r_ctrl[CTRL_IRQ_EN];
      end
   end

   assign IOBUS_IN = r_iobus_in;
   assign LEDS     = r_led;
   assign INTR     = r_intr;

endmodule
